// File: rtl/mpu_load_if.sv
// Interface between the MPU LOAD controller, the decode/bus side and the matrix register file.
// The slave modport is used by mpu_load_controller. The master modport is used by whatever drives it.
interface mpu_load_if #(
   parameter int FP               = 32,
   parameter int M                = 5,
   parameter int N                = 5,
   parameter int MATRIX_REGISTERS = 8
);
   localparam int MBITS           = $clog2(M);
   localparam int NBITS           = $clog2(N);
   localparam int MATRIX_REG_BITS = $clog2(MATRIX_REGISTERS);

   logic                       load_req;
   logic                       load_ready;
   logic [MBITS:0]             m_in;
   logic [NBITS:0]             n_in;
   logic [MATRIX_REG_BITS:0]   matrix_addr;
   logic                       elem_valid;
   logic [FP-1:0]              elem_in;
   logic                       elem_ready;
   logic                       wr_en;
   logic [MATRIX_REG_BITS:0]   wr_addr;
   logic [MBITS:0]             wr_row;
   logic [NBITS:0]             wr_col;
   logic [FP-1:0]              wr_data;
   logic                       load_done;
   logic                       load_error;

   modport slave (
      input  load_req, m_in, n_in, matrix_addr, elem_valid, elem_in,
      output load_ready, elem_ready, wr_en, wr_addr, wr_row, wr_col, wr_data,
             load_done, load_error
   );

   modport master (
      output load_req, m_in, n_in, matrix_addr, elem_valid, elem_in,
      input  load_ready, elem_ready, wr_en, wr_addr, wr_row, wr_col, wr_data,
             load_done, load_error
   );
endinterface

// File: rtl/mpu_load_controller.sv
// MPU LOAD controller: latches one request, then streams float_sp elements row-major into the
// matrix register file. Define MPU_LOAD_ZERO_FILL_EN to write +0.0 to every position outside m x n.
module mpu_load_controller #(
   parameter int FP               = 32,
   parameter int M                = 5,
   parameter int N                = 5,
   parameter int MATRIX_REGISTERS = 8
) (
   input  logic     clk,
   input  logic     rst,
   mpu_load_if.slave bus
);
   localparam int MBITS           = $clog2(M);
   localparam int NBITS           = $clog2(N);
   localparam int MATRIX_REG_BITS = $clog2(MATRIX_REGISTERS);

   localparam logic [MBITS:0] M_LIM    = (MBITS+1)'(M);
   localparam logic [NBITS:0] N_LIM    = (NBITS+1)'(N);
   localparam logic [MBITS:0] ROW_ONE  = (MBITS+1)'(1);
   localparam logic [NBITS:0] COL_ONE  = (NBITS+1)'(1);
   localparam logic [MBITS:0] ROW_ZERO = (MBITS+1)'(0);
   localparam logic [NBITS:0] COL_ZERO = (NBITS+1)'(0);

   typedef enum logic [1:0] {
      LOAD_IDLE    = 2'd0,
      LOAD_REQUEST = 2'd1,
      LOAD_MATRIX  = 2'd2
   } load_state_e;

   load_state_e              state_r, state_s;
   logic [MBITS:0]           m_r, row_r, row_s, row_end_s;
   logic [NBITS:0]           n_r, col_r, col_s, col_end_s;
   logic [MATRIX_REG_BITS:0] addr_r;
   logic                     write_s, pad_s, done_s, error_s, dims_bad_s, ready_s;

   logic                     load_ready_r, elem_ready_r, wr_en_r, load_done_r, load_error_r;
   logic [MATRIX_REG_BITS:0] wr_addr_r;
   logic [MBITS:0]           wr_row_r;
   logic [NBITS:0]           wr_col_r;
   logic [FP-1:0]            wr_data_r;

   // Next-state, counter advance and write/terminal decode.
   always_comb begin
      state_s    = state_r;
      row_s      = row_r;
      col_s      = col_r;
      write_s    = 1'b0;
      pad_s      = 1'b0;
      done_s     = 1'b0;
      error_s    = 1'b0;
      row_end_s  = M_LIM - ROW_ONE;
      col_end_s  = N_LIM - COL_ONE;
      dims_bad_s = (m_r == ROW_ZERO) || (m_r > M_LIM) || (n_r == COL_ZERO) || (n_r > N_LIM);
      case (state_r)
         LOAD_IDLE: begin
            if (bus.load_req) begin
               state_s = LOAD_REQUEST;
            end else begin
               state_s = LOAD_IDLE;
            end
         end
         LOAD_REQUEST: begin
            if (dims_bad_s) begin
               error_s = 1'b1;
               state_s = LOAD_IDLE;
            end else begin
               row_s   = ROW_ZERO;
               col_s   = COL_ZERO;
               state_s = LOAD_MATRIX;
            end
         end
         LOAD_MATRIX: begin
`ifdef MPU_LOAD_ZERO_FILL_EN
            pad_s   = (row_r >= m_r) || (col_r >= n_r);
            write_s = pad_s || (bus.elem_valid && elem_ready_r);
`else
            row_end_s = m_r - ROW_ONE;
            col_end_s = n_r - COL_ONE;
            write_s   = bus.elem_valid && elem_ready_r;
`endif
            if (write_s) begin
               if (col_r == col_end_s) begin
                  col_s = COL_ZERO;
                  row_s = row_r + ROW_ONE;
               end else begin
                  col_s = col_r + COL_ONE;
                  row_s = row_r;
               end
               if ((row_r == row_end_s) && (col_r == col_end_s)) begin
                  done_s  = 1'b1;
                  state_s = LOAD_IDLE;
               end else begin
                  state_s = LOAD_MATRIX;
               end
            end else begin
               state_s = LOAD_MATRIX;
            end
         end
         default: begin
            state_s = LOAD_IDLE;
         end
      endcase
   end

   // elem_ready for the next cycle; padding positions never accept an element.
   always_comb begin
      ready_s = 1'b0;
      if (state_s == LOAD_MATRIX) begin
`ifdef MPU_LOAD_ZERO_FILL_EN
         ready_s = (row_s < m_r) && (col_s < n_r);
`else
         ready_s = 1'b1;
`endif
      end else begin
         ready_s = 1'b0;
      end
   end

   // State, request latch and position counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= LOAD_IDLE;
         m_r     <= ROW_ZERO;
         n_r     <= COL_ZERO;
         addr_r  <= '0;
         row_r   <= ROW_ZERO;
         col_r   <= COL_ZERO;
      end else begin
         state_r <= state_s;
         row_r   <= row_s;
         col_r   <= col_s;
         if ((state_r == LOAD_IDLE) && bus.load_req) begin
            m_r    <= bus.m_in;
            n_r    <= bus.n_in;
            addr_r <= bus.matrix_addr;
         end else begin
            m_r    <= m_r;
            n_r    <= n_r;
            addr_r <= addr_r;
         end
      end
   end

   // Registered outputs: the write port lags the accepting edge by one cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         load_ready_r <= 1'b1;
         elem_ready_r <= 1'b0;
         wr_en_r      <= 1'b0;
         load_done_r  <= 1'b0;
         load_error_r <= 1'b0;
         wr_addr_r    <= '0;
         wr_row_r     <= ROW_ZERO;
         wr_col_r     <= COL_ZERO;
         wr_data_r    <= {FP{1'b0}};
      end else begin
         load_ready_r <= (state_s == LOAD_IDLE);
         elem_ready_r <= ready_s;
         wr_en_r      <= write_s;
         load_done_r  <= done_s;
         load_error_r <= error_s;
         if (write_s) begin
            wr_addr_r <= addr_r;
            wr_row_r  <= row_r;
            wr_col_r  <= col_r;
            wr_data_r <= pad_s ? {FP{1'b0}} : bus.elem_in;
         end else begin
            wr_addr_r <= wr_addr_r;
            wr_row_r  <= wr_row_r;
            wr_col_r  <= wr_col_r;
            wr_data_r <= wr_data_r;
         end
      end
   end

   assign bus.load_ready = load_ready_r;
   assign bus.elem_ready = elem_ready_r;
   assign bus.wr_en      = wr_en_r;
   assign bus.wr_addr    = wr_addr_r;
   assign bus.wr_row     = wr_row_r;
   assign bus.wr_col     = wr_col_r;
   assign bus.wr_data    = wr_data_r;
   assign bus.load_done  = load_done_r;
   assign bus.load_error = load_error_r;
endmodule
